// File: rtl/spi_ram_ctrl.sv
// rtl/spi_ram_ctrl.sv - command-decoded RAM behind the SPI slave with a timed read window
// Optional feature: define AUTO_INC_EN for post-access pointer auto-increment.
module spi_ram_ctrl #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int MEM_DEPTH = 256,
  parameter int TX_HOLD   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_valid,
  input  logic [DATA_W+1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              tx_valid,
  output logic              busy,
  output logic              cmd_err
);

  localparam int CNT_W = (TX_HOLD > 1) ? $clog2(TX_HOLD) : 1;

  localparam logic [1:0] CMD_SET_WR = 2'b00;
  localparam logic [1:0] CMD_WRITE  = 2'b01;
  localparam logic [1:0] CMD_SET_RD = 2'b10;
  localparam logic [1:0] CMD_READ   = 2'b11;

  typedef enum logic {S_IDLE, S_HOLD} state_t;

  logic [DATA_W-1:0] r_mem [MEM_DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0]  r_cnt;
  state_t            r_state;
  logic [DATA_W-1:0] r_dout;
  logic              r_tx_valid;
  logic              r_cmd_err;

  logic [1:0]        w_cmd;
  logic [DATA_W-1:0] w_payload;
  logic [ADDR_W-1:0] w_addr;
  logic              w_addr_ok;

  assign w_cmd     = din[DATA_W+1:DATA_W];
  assign w_payload = din[DATA_W-1:0];
  assign w_addr    = w_payload[ADDR_W-1:0];
  // Extra bit so MEM_DEPTH == 2**ADDR_W still compares correctly.
  assign w_addr_ok = {1'b0, w_addr} < (ADDR_W+1)'(MEM_DEPTH);

`ifdef AUTO_INC_EN
  function automatic logic [ADDR_W-1:0] f_inc(input logic [ADDR_W-1:0] p);
    return (p == ADDR_W'(MEM_DEPTH - 1)) ? '0 : p + ADDR_W'(1);
  endfunction
`endif

  always_ff @(posedge clk) begin
    if (rst_n && rx_valid && (w_cmd == CMD_WRITE)) begin
      r_mem[r_wr_ptr] <= w_payload;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_cnt      <= '0;
      r_state    <= S_IDLE;
      r_dout     <= '0;
      r_tx_valid <= 1'b0;
      r_cmd_err  <= 1'b0;
    end else begin
      r_cmd_err <= 1'b0;

      if (r_state == S_HOLD) begin
        if (r_cnt == CNT_W'(TX_HOLD - 1)) begin
          r_state    <= S_IDLE;
          r_tx_valid <= 1'b0;
          r_cnt      <= '0;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end

      if (rx_valid) begin
        case (w_cmd)
          CMD_SET_WR: begin
            if (w_addr_ok) r_wr_ptr <= w_addr;
            else           r_cmd_err <= 1'b1;
          end
          CMD_WRITE: begin
`ifdef AUTO_INC_EN
            r_wr_ptr <= f_inc(r_wr_ptr);
`endif
          end
          CMD_SET_RD: begin
            if (w_addr_ok) r_rd_ptr <= w_addr;
            else           r_cmd_err <= 1'b1;
          end
          CMD_READ: begin
            // A read arriving on the window's final edge is still dropped.
            if (r_state == S_IDLE) begin
              r_dout     <= r_mem[r_rd_ptr];
              r_tx_valid <= 1'b1;
              r_cnt      <= '0;
              r_state    <= S_HOLD;
`ifdef AUTO_INC_EN
              r_rd_ptr   <= f_inc(r_rd_ptr);
`endif
            end else begin
              r_cmd_err <= 1'b1;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign dout     = r_dout;
  assign tx_valid = r_tx_valid;
  assign busy     = r_tx_valid;
  assign cmd_err  = r_cmd_err;

endmodule

// File: doc/spi_ram_ctrl.md
Name: spi_ram_ctrl

Overview:
Parametrised command-decoded single-port RAM behind the SPI slave. Consumes framed words {cmd[1:0], payload} from the SPI receive path. Keeps separate write and read address pointers, with optional auto-increment. Presents read data with a timed tx_valid window for the SPI transmit shifter.

Parameters:
DATA_W, 8, RAM word width and payload width of din
ADDR_W, 8, pointer width; must be <= DATA_W
MEM_DEPTH, 256, number of RAM words; must be <= 2**ADDR_W
TX_HOLD, 8, cycles tx_valid stays high per read; must be >= 1

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset; synchronous, active-low
rx_valid  in  1  din valid strobe from SPI receiver, one cycle per frame
din  in  DATA_W+2  [DATA_W+1:DATA_W]=cmd, [DATA_W-1:0]=payload
dout  out  DATA_W  read data to SPI transmitter
tx_valid  out  1  dout valid window
busy  out  1  high while a read window is in progress (equals tx_valid)
cmd_err  out  1  one-cycle pulse on a rejected command

Behaviour:
- Reset (rst_n=0 at a rising edge) sets: dout=0, tx_valid=0, busy=0, cmd_err=0, wr_ptr=0, rd_ptr=0, hold counter=0, FSM=IDLE.
- RAM contents are not reset.
- Reset has priority over everything, including a read window in progress.
- All commands are evaluated only on an edge where rx_valid=1. When rx_valid=0, only the hold logic runs.
- cmd 00, SET_WR:
  - If payload[ADDR_W-1:0] < MEM_DEPTH, wr_ptr is loaded with it.
  - Otherwise wr_ptr is unchanged and cmd_err pulses.
  - Payload bits above ADDR_W are ignored.
- cmd 01, WRITE:
  - mem[wr_ptr] <= payload.
  - With AUTO_INC_EN, wr_ptr increments and wraps MEM_DEPTH-1 -> 0.
- cmd 10, SET_RD: same rules as SET_WR, applied to rd_ptr.
- cmd 11, READ, in IDLE:
  - dout <= mem[rd_ptr] and tx_valid <= 1 on the same edge (1-cycle latency from rx_valid).
  - Counter <= 0; FSM -> HOLD.
  - With AUTO_INC_EN, rd_ptr increments and wraps.
- cmd 11, READ, in HOLD: dropped. dout, rd_ptr and counter are unchanged; cmd_err pulses.
- FSM states:
  - IDLE: tx_valid=0.
  - HOLD: tx_valid=1. The counter increments every cycle. When counter==TX_HOLD-1, go to IDLE with tx_valid<=0 on that edge, so tx_valid is high for exactly TX_HOLD cycles.
- cmd 00/01/10 during HOLD are executed normally and do not disturb dout, tx_valid or the counter.
- dout holds its last read value after tx_valid falls, until the next accepted READ or a reset.
- Write then read of the same address on consecutive frames returns the new data (registered write, next-frame read).
- cmd_err is high for exactly one cycle per rejected command and is 0 otherwise.

Optional Feature:
AUTO_INC_EN
- Defined: wr_ptr advances after every WRITE and rd_ptr after every accepted READ, each wrapping at MEM_DEPTH. This allows burst transfers without re-addressing.
- Undefined: both pointers change only on SET_WR/SET_RD, and repeated READs return the same word.
- All other behaviour is identical.

Test Plan:
- Reset, then SET_WR 0x10, WRITE 0xA5, SET_RD 0x10, READ -> dout=0xA5, tx_valid high for exactly 8 cycles starting one cycle after the READ rx_valid; cmd_err stays 0.
- (AUTO_INC_EN) SET_WR 0xFE, WRITE 0x11, 0x22, 0x33, then SET_RD 0xFE and three READs spaced 10 cycles apart -> dout 0x11, 0x22, 0x33 (address 0xFF then wrap to 0x00).
- READ issued 3 cycles into a hold window -> cmd_err one-cycle pulse; dout unchanged; tx_valid still falls 8 cycles after the original READ.
- MEM_DEPTH=200: SET_RD 0xF0 -> cmd_err pulse and rd_ptr unchanged; a following READ returns the word at the previous rd_ptr.
- rst_n=0 during the 4th cycle of a hold window -> next edge: tx_valid=0, dout=0, busy=0. After release, the READ sequence behaves as in the first scenario.
- WRITE 0x5A at wr_ptr 0x20 during a hold window -> tx_valid window length unaffected. A later SET_RD 0x20 then READ -> dout=0x5A.
